alu_cmd_issuer: RTL and testbench

- Upstream issue stage for the 4-bit ALU.
- Accepts tagged commands (opcode, A, B) over a valid/ready handshake and buffers them in a small FIFO.
- Drives the ALU operand/opcode inputs one command at a time and captures the ALU's registered 5-bit result one cycle later.
- Returns result plus tag over a valid/ready output, preserving command order.

---
 rtl/alu_cmd_issuer_pkg.sv | 20 ++
 rtl/alu_cmd_fifo.sv | 42 ++++
 rtl/alu_cmd_issuer.sv | 135 +++++++++++++
 tb/tb_alu_cmd_issuer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_cmd_issuer_pkg.sv
// Shared types for the ALU command issuer: ALU opcodes, datapath widths, FSM states.
package alu_cmd_issuer_pkg;

  typedef enum logic [1:0] {
    ADD     = 2'd0,
    SUB     = 2'd1,
    NOT_A   = 2'd2,
    REDOR_B = 2'd3
  } opcode_t;

  localparam int DATA_W = 4;
  localparam int RES_W  = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    CAPT = 2'd2
  } state_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; pointers carry one extra wrap bit so full/empty come from an MSB compare.
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, rptr_q;
  logic             do_push, do_pop;

  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Issue stage for the 4-bit ALU: buffers tagged commands, runs them through the ALU one at a time,
// and returns result+tag in order over a valid/ready output.
//
// state | meaning
// IDLE  | ALU inputs hold last operands; wait for a command and a free result slot
// EXEC  | ALU inputs stable; ALU registers C at the closing edge
// CAPT  | alu_c valid; write result register, chain to next command if possible
module alu_cmd_issuer
  import alu_cmd_issuer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_opcode,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RES_W-1:0]  out_result,
  output logic [TAG_W-1:0]  out_tag,
  output logic [1:0]        alu_opcode,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [RES_W-1:0]  alu_c,
  output logic              busy
);

  localparam int CMD_W = 2 + 2*DATA_W + TAG_W;

  state_t              state_q, state_d;
  opcode_t             op_q, op_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [RES_W-1:0]    res_q, res_d;
  logic [TAG_W-1:0]    otag_q, otag_d;
  logic                ovalid_q, ovalid_d;

  logic                fifo_full, fifo_empty, pop;
  logic [CMD_W-1:0]    head;
  logic [1:0]          head_op;
  logic [DATA_W-1:0]   head_a, head_b;
  logic [TAG_W-1:0]    head_tag;

  assign {head_op, head_a, head_b, head_tag} = head;

  alu_cmd_fifo #(.DEPTH(DEPTH), .WIDTH(CMD_W)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (in_valid && !fifo_full),
    .wdata_i ({in_opcode, in_a, in_b, in_tag}),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    tag_d    = tag_q;
    res_d    = res_q;
    otag_d   = otag_q;
    ovalid_d = ovalid_q && !out_ready;
    pop      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && (!ovalid_q || out_ready)) begin
          pop     = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: state_d = CAPT;
      CAPT: begin
        // Never overwrite an unconsumed result; the ALU keeps recomputing the held operands.
        if (!ovalid_q || out_ready) begin
          res_d    = alu_c;
          otag_d   = tag_q;
          ovalid_d = 1'b1;
          if (!fifo_empty && out_ready) begin
            pop     = 1'b1;
            state_d = EXEC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (pop) begin
      op_d  = opcode_t'(head_op);
      a_d   = head_a;
      b_d   = head_b;
      tag_d = head_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= ADD;
      a_q      <= '0;
      b_q      <= '0;
      tag_q    <= '0;
      res_q    <= '0;
      otag_q   <= '0;
      ovalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      tag_q    <= tag_d;
      res_q    <= res_d;
      otag_q   <= otag_d;
      ovalid_q <= ovalid_d;
    end
  end

  assign in_ready   = !fifo_full;
  assign out_valid  = ovalid_q;
  assign out_result = res_q;
  assign out_tag    = otag_q;
  assign alu_opcode = op_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign busy       = !fifo_empty || (state_q != IDLE) || ovalid_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer with a registered 4-bit ALU model closing the loop.
module tb_alu_cmd_issuer;

  localparam logic [1:0] OP_ADD = 2'd0, OP_SUB = 2'd1, OP_NOT = 2'd2, OP_ROR = 2'd3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0, in_ready;
  logic [1:0] in_opcode = '0;
  logic [3:0] in_a = '0, in_b = '0, in_tag = '0;
  logic       out_valid, out_ready = 1'b1;
  logic [4:0] out_result;
  logic [3:0] out_tag;
  logic [1:0] alu_opcode;
  logic [3:0] alu_a, alu_b;
  logic [4:0] alu_c;
  logic       busy;

  int n_tests = 0, n_fail = 0, cyc = 0;
  logic [4:0] res_q[$];
  logic [3:0] tag_q[$];
  int         cyc_q[$];

  alu_cmd_issuer #(.DEPTH(4), .TAG_W(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] alu_f(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      2'd0:    return {a[3], a} + {b[3], b};
      2'd1:    return {a[3], a} - {b[3], b};
      2'd2:    return ~{a[3], a};
      default: return {4'b0, |b};
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) alu_c <= '0;
    else       alu_c <= alu_f(alu_opcode, alu_a, alu_b);
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      res_q.push_back(out_result);
      tag_q.push_back(out_tag);
      cyc_q.push_back(cyc);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic push_cmd(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] tag);
    int n = 0;
    in_valid = 1'b1; in_opcode = op; in_a = a; in_b = b; in_tag = tag;
    @(negedge clk);
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) check("push_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_results(input int n, input int budget);
    int k = 0;
    while (res_q.size() < n && k < budget) begin @(negedge clk); k++; end
    if (res_q.size() < n) check("drain_timeout", 32'(res_q.size()), 32'(n));
  endtask

  function automatic int fifo_cnt();
    return int'(dut.u_fifo.wptr_q - dut.u_fifo.rptr_q) & 7;
  endfunction

  logic [4:0] r0;
  logic [3:0] t0;
  logic [4:0] exp4_res[6] = '{5'h07, 5'h1D, 5'h1A, 5'h01, 5'h10, 5'h0F};
  logic [4:0] exp6_res[5] = '{5'h02, 5'h03, 5'h04, 5'h1F, 5'h1F};

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_alu", {alu_opcode, alu_a, alu_b, out_result, out_tag}, 0);
    @(posedge clk); #1;

    // Test 1: latency, ADD 7+7
    push_cmd(OP_ADD, 4'd7, 4'd7, 4'd1);
    @(negedge clk); check("t1_ov_k0", 32'(out_valid), 0); check("t1_busy", 32'(busy), 1);
    @(negedge clk); check("t1_ov_k1", 32'(out_valid), 0); check("t1_alu_a", 32'(alu_a), 7);
    @(negedge clk); check("t1_ov_k2", 32'(out_valid), 0);
    @(negedge clk); check("t1_ov_k3", 32'(out_valid), 1);
    check("t1_res", 32'(out_result), 32'h0E); check("t1_tag", 32'(out_tag), 1);
    @(negedge clk); check("t1_ov_k4", 32'(out_valid), 0); check("t1_busy_end", 32'(busy), 0);
    @(posedge clk); #1;

    // Test 2: SUB -8-7
    push_cmd(OP_SUB, 4'h8, 4'd7, 4'd2);
    @(negedge clk);
    @(negedge clk);
    check("t2_alu_op", 32'(alu_opcode), 32'(OP_SUB));
    check("t2_alu_a", 32'(alu_a), 32'h8); check("t2_alu_b", 32'(alu_b), 7);
    @(negedge clk);
    @(negedge clk); check("t2_ov", 32'(out_valid), 1);
    check("t2_res", 32'(out_result), 32'h11); check("t2_tag", 32'(out_tag), 2);
    @(posedge clk); #1;

    // Test 3: back-to-back REDOR_B
    repeat (3) @(posedge clk); #1;
    res_q.delete(); tag_q.delete(); cyc_q.delete();
    push_cmd(OP_ROR, 4'd0, 4'b0000, 4'd3);
    push_cmd(OP_ROR, 4'd0, 4'b0100, 4'd4);
    wait_results(2, 20);
    if (res_q.size() >= 2) begin
      check("t3_res0", 32'(res_q[0]), 0); check("t3_tag0", 32'(tag_q[0]), 3);
      check("t3_res1", 32'(res_q[1]), 1); check("t3_tag1", 32'(tag_q[1]), 4);
      check("t3_gap", 32'(cyc_q[1] - cyc_q[0]), 2);
    end
    repeat (3) @(posedge clk); #1;

    // Test 4: backpressure, FIFO fill, ordered drain
    out_ready = 1'b0;
    res_q.delete(); tag_q.delete(); cyc_q.delete();
    push_cmd(OP_ADD, 4'd3, 4'd4, 4'd5);
    push_cmd(OP_SUB, 4'd2, 4'd5, 4'd6);
    push_cmd(OP_NOT, 4'b0101, 4'd0, 4'd7);
    push_cmd(OP_ROR, 4'd0, 4'b1000, 4'd8);
    push_cmd(OP_ADD, 4'h8, 4'h8, 4'd9);
    repeat (4) @(negedge clk);
    check("t4_full", 32'(in_ready), 0);
    check("t4_ov", 32'(out_valid), 1);
    check("t4_hold_tag", 32'(out_tag), 5);
    check("t4_hold_res", 32'(out_result), 32'h07);
    r0 = out_result; t0 = out_tag;
    repeat (3) begin
      @(negedge clk);
      check("t4_stable", {out_valid, out_result, out_tag}, {1'b1, r0, t0});
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    push_cmd(OP_SUB, 4'd7, 4'h8, 4'd10);
    wait_results(6, 60);
    repeat (4) @(negedge clk);
    check("t4_count", 32'(res_q.size()), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < res_q.size()) begin
        check($sformatf("t4_tag%0d", i), 32'(tag_q[i]), 32'(5 + i));
        check($sformatf("t4_res%0d", i), 32'(res_q[i]), 32'(exp4_res[i]));
      end
    end
    @(posedge clk); #1;

    // Test 5: reset during EXEC with two commands queued
    push_cmd(OP_ADD, 4'd1, 4'd1, 4'd1);
    push_cmd(OP_ADD, 4'd5, 4'd1, 4'd2);
    push_cmd(OP_ADD, 4'd2, 4'd1, 4'd3);
    push_cmd(OP_ADD, 4'd3, 4'd1, 4'd4);
    @(negedge clk);
    check("t5_exec_a", 32'(alu_a), 5);
    check("t5_queued", 32'(fifo_cnt()), 2);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    res_q.delete(); tag_q.delete(); cyc_q.delete();
    @(negedge clk);
    check("t5_ov", 32'(out_valid), 0); check("t5_busy", 32'(busy), 0);
    check("t5_in_ready", 32'(in_ready), 1);
    check("t5_alu", {alu_opcode, alu_a, alu_b}, 0);
    check("t5_fifo", 32'(fifo_cnt()), 0);
    repeat (6) @(negedge clk);
    check("t5_no_out", 32'(res_q.size()), 0);
    check("t5_busy_late", 32'(busy), 0);
    @(posedge clk); #1;

    // Test 6: push and pop on the same edge at DEPTH-1
    out_ready = 1'b0;
    push_cmd(OP_ADD, 4'd1, 4'd1, 4'd11);
    push_cmd(OP_ADD, 4'd1, 4'd2, 4'd12);
    push_cmd(OP_ADD, 4'd2, 4'd2, 4'd13);
    push_cmd(OP_SUB, 4'd0, 4'd1, 4'd14);
    repeat (4) @(negedge clk);
    check("t6_pre_cnt", 32'(fifo_cnt()), 3);
    check("t6_pre_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b1; in_opcode = OP_NOT; in_a = 4'd0; in_b = 4'd0; in_tag = 4'd15;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("t6_post_cnt", 32'(fifo_cnt()), 3);
    check("t6_post_ready", 32'(in_ready), 1);
    wait_results(5, 60);
    for (int i = 0; i < 5; i++) begin
      if (i < res_q.size()) begin
        check($sformatf("t6_tag%0d", i), 32'(tag_q[i]), 32'(11 + i));
        check($sformatf("t6_res%0d", i), 32'(res_q[i]), 32'(exp6_res[i]));
      end
    end
    repeat (4) @(negedge clk);
    check("t6_idle", 32'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
